// File: rtl/psd_cmd_pkg.sv
// Shared types and helpers for the UART command decoder: FSM states, frame
// layout constants and the frame/response checksum.
package psd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_CSUM,
        ST_EXEC,
        ST_RESP
    } cmd_state_t;

    localparam int         FRAME_BYTES          = 4;
    localparam int         WR_BIT               = 7;
    localparam logic [6:0] BROADCAST_ID_DEFAULT = 7'h7F;

    function automatic logic [7:0] cmd_csum(input logic [7:0] hdr,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
        return hdr ^ addr ^ data;
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry on
// the last allowed cycle; any clear or disable restarts it from zero.
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving on the last allowed cycle wins over expiry.
    assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/cmd_decoder.sv
// Assembles 4-byte command frames from the UART receiver, issues register
// writes or streams a 4-byte read response, and counts framing errors.
module cmd_decoder
    import psd_cmd_pkg::*;
#(
    parameter int         NUMREGS        = 67,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [6:0] BROADCAST_ID   = BROADCAST_ID_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] chip_id,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_err,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam logic [7:0] NUMREGS_W = 8'(NUMREGS);
    localparam logic [1:0] LAST_IDX  = 2'(FRAME_BYTES - 1);

    cmd_state_t state, state_d;

    logic [7:0] hdr_q;
    logic [7:0] addr_q;
    logic [7:0] rd_q;
    logic [1:0] tx_idx;

    logic       in_get, expired, csum_ok, abort;
    logic       err_evt, start_resp, resp_done;
    logic       cap_hdr, cap_addr, cap_data;
    logic [6:0] hdr_id;
    logic       hdr_wr, to_me, is_bc, in_range;
    logic       wr_target, rd_target, write_ok, read_ok, addr_err;
    logic [7:0] resp_hdr, next_byte;

    assign in_get = (state == ST_GET_ADDR) || (state == ST_GET_DATA) || (state == ST_GET_CSUM);

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (rx_valid),
        .enable (in_get),
        .expired(expired)
    );

    // The full 8-bit address byte is kept so 0x80+ never aliases into range.
    assign reg_addr  = addr_q[6:0];
    assign hdr_id    = hdr_q[6:0];
    assign hdr_wr    = hdr_q[WR_BIT];
    assign to_me     = (hdr_id == chip_id);
    assign is_bc     = (hdr_id == BROADCAST_ID);
    assign in_range  = (addr_q < NUMREGS_W);
    assign wr_target = hdr_wr && (to_me || is_bc);
    assign rd_target = !hdr_wr && to_me && !is_bc;
    assign write_ok  = wr_target && in_range;
    assign read_ok   = rd_target && in_range;
    assign addr_err  = (wr_target || rd_target) && !in_range;

    assign csum_ok   = (rx_data == cmd_csum(hdr_q, addr_q, reg_wr_data));
    assign abort     = in_get && ((rx_valid && rx_frame_err) || expired);
    assign resp_done = (state == ST_RESP) && tx_valid && tx_ready && (tx_idx == LAST_IDX);

    assign reg_wr_en = (state == ST_EXEC) && write_ok;
    assign busy      = (state != ST_IDLE);
    assign resp_hdr  = {1'b0, chip_id};

    always_comb begin
        case (tx_idx)
            2'd0:    next_byte = addr_q;
            2'd1:    next_byte = rd_q;
            default: next_byte = cmd_csum(resp_hdr, addr_q, rd_q);
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        err_evt    = 1'b0;
        cap_hdr    = 1'b0;
        cap_addr   = 1'b0;
        cap_data   = 1'b0;
        start_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_frame_err) begin
                    err_evt = 1'b1;
                end else if (rx_valid) begin
                    cap_hdr = 1'b1;
                    state_d = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid && !rx_frame_err) begin
                    cap_addr = 1'b1;
                    state_d  = ST_GET_DATA;
                end
            end
            ST_GET_DATA: begin
                if (rx_valid && !rx_frame_err) begin
                    cap_data = 1'b1;
                    state_d  = ST_GET_CSUM;
                end
            end
            ST_GET_CSUM: begin
                if (rx_valid && !rx_frame_err) begin
                    err_evt = !csum_ok;
                    state_d = csum_ok ? ST_EXEC : ST_IDLE;
                end
            end
            ST_EXEC: begin
                err_evt    = rx_valid || addr_err;
                start_resp = read_ok;
                state_d    = read_ok ? ST_RESP : ST_IDLE;
            end
            ST_RESP: begin
                err_evt = rx_valid;
                if (resp_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            err_evt = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q       <= '0;
            addr_q      <= '0;
            reg_wr_data <= '0;
            rd_q        <= '0;
            tx_idx      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            err_count   <= '0;
        end else begin
            if (cap_hdr)  hdr_q       <= rx_data;
            if (cap_addr) addr_q      <= rx_data;
            if (cap_data) reg_wr_data <= rx_data;
            if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (start_resp) begin
                rd_q     <= reg_rd_data;
                tx_data  <= resp_hdr;
                tx_valid <= 1'b1;
                tx_idx   <= '0;
            end else if ((state == ST_RESP) && tx_valid && tx_ready) begin
                if (resp_done) begin
                    tx_valid <= 1'b0;
                end else begin
                    tx_idx  <= tx_idx + 2'd1;
                    tx_data <= next_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_decoder.sv
// Self-checking bench for cmd_decoder: frame-level reference model with a
// per-cycle compare process, directed literal cases and randomized frames.
module tb_cmd_decoder;

    localparam int         NUMREGS = 67;
    localparam int         TIMEOUT = 4096;
    localparam logic [6:0] CHIP    = 7'h01;
    localparam logic [6:0] BC      = 7'h7F;

    logic       clk, reset_n;
    logic [6:0] chip_id;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic [7:0] reg_rd_data;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] err_count;
    logic       busy;

    cmd_decoder #(
        .NUMREGS       (NUMREGS),
        .TIMEOUT_CYCLES(TIMEOUT),
        .BROADCAST_ID  (BC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chip_id     (chip_id),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_data (reg_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .err_count   (err_count),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register map stub ----------------
    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 11) ^ 8'h5A;
    endfunction

    logic [7:0] regmap [128];
    assign reg_rd_data = regmap[reg_addr];

    initial begin
        for (int i = 0; i < 128; i++) regmap[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (reset_n && reg_wr_en === 1'b1) regmap[reg_addr] = reg_wr_data;
        end
    end

    // ---------------- tx_ready pattern ----------------
    int ready_mode = 0;  // 0 always, 1 toggle every 3 cycles, 2 random, 3 held low
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       if (cyc % 3 == 0) tx_ready = ~tx_ready;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    typedef enum int {ACT_WRITE, ACT_READ, ACT_ERR, ACT_SILENT} act_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic [6:0]  addr;
        logic [7:0]  data;
    } wr_ev_t;
    typedef struct packed {
        logic [31:0]     start;
        logic [3:0][7:0] b;
    } resp_t;

    wr_ev_t     exp_wr_q[$];
    resp_t      exp_resp_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] mregs [128];
    int         merr = 0;

    function automatic act_t frame_action(input logic [7:0] h, input logic [7:0] a,
                                          input logic [7:0] d, input logic [7:0] s);
        logic [6:0] id;
        logic       wr;
        id = h[6:0];
        wr = h[7];
        if (s != (h ^ a ^ d))              return ACT_ERR;
        if (wr && (id == CHIP || id == BC)) return (a < NUMREGS) ? ACT_WRITE : ACT_ERR;
        if (!wr && id == CHIP)              return (a < NUMREGS) ? ACT_READ : ACT_ERR;
        return ACT_SILENT;
    endfunction

    task automatic model_err();
        if (merr < 255) merr++;
    endtask

    task automatic expect_frame(input logic [7:0] h, input logic [7:0] a,
                                input logic [7:0] d, input logic [7:0] s, input int c);
        resp_t r;
        case (frame_action(h, a, d, s))
            ACT_WRITE: begin
                exp_wr_q.push_back('{cyc: 32'(c + 1), addr: a[6:0], data: d});
                mregs[a[6:0]] = d;
            end
            ACT_READ: begin
                r.start = 32'(c + 2);
                r.b[0]  = {1'b0, CHIP};
                r.b[1]  = a;
                r.b[2]  = mregs[a[6:0]];
                r.b[3]  = {1'b0, CHIP} ^ a ^ mregs[a[6:0]];
                exp_resp_q.push_back(r);
            end
            ACT_ERR:  model_err();
            default:  ;
        endcase
    endtask

    // ---------------- per-cycle compare process ----------------
    int   wr_ptr = 0;
    int   resp_ptr = 0;
    bit   mon_active = 0;
    int   mon_idx = 0;
    logic exp_we;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            wr_ptr     = exp_wr_q.size();
            resp_ptr   = exp_resp_q.size();
            mon_active = 0;
        end else begin
            while (wr_ptr < exp_wr_q.size() && int'(exp_wr_q[wr_ptr].cyc) < cyc) wr_ptr++;
            exp_we = (wr_ptr < exp_wr_q.size()) && (int'(exp_wr_q[wr_ptr].cyc) == cyc);
            check("reg_wr_en", reg_wr_en, exp_we);
            if (exp_we) begin
                check("reg_addr", reg_addr, exp_wr_q[wr_ptr].addr);
                check("reg_wr_data", reg_wr_data, exp_wr_q[wr_ptr].data);
                wr_ptr++;
            end
            if (!mon_active && resp_ptr < exp_resp_q.size() &&
                int'(exp_resp_q[resp_ptr].start) == cyc) begin
                mon_active = 1;
                mon_idx    = 0;
            end
            check("tx_valid", tx_valid, mon_active);
            if (mon_active) begin
                check("tx_data", tx_data, exp_resp_q[resp_ptr].b[mon_idx]);
                if (tx_ready) begin
                    tx_log.push_back(tx_data);
                    mon_idx++;
                    if (mon_idx == 4) begin
                        mon_active = 0;
                        resp_ptr++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ferr, output int c);
        rx_data      = b;
        rx_frame_err = ferr;
        rx_valid     = 1'b1;
        c            = cyc;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] s, input int max_gap, output int c_csum);
        int c;
        send_byte(h, 1'b0, c);
        idle($urandom_range(0, max_gap));
        send_byte(a, 1'b0, c);
        idle($urandom_range(0, max_gap));
        send_byte(d, 1'b0, c);
        idle($urandom_range(0, max_gap));
        send_byte(s, 1'b0, c);
        expect_frame(h, a, d, s, c);
        c_csum = c;
    endtask

    task automatic settle();
        int i;
        for (i = 0; i < 400; i++) begin
            if (resp_ptr == exp_resp_q.size()) break;
            idle(1);
        end
        check("resp_complete", 32'(resp_ptr == exp_resp_q.size()), 32'd1);
        idle(2);
        check("busy_idle", busy, 1'b0);
        check("err_count", err_count, merr);
    endtask

    task automatic check_log(input int n0, input logic [31:0] lit, input string name);
        logic [7:0] e;
        if (tx_log.size() < n0 + 4) begin
            check({name, "_len"}, tx_log.size(), n0 + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = lit[31 - 8*i -: 8];
                check(name, tx_log[n0 + i], e);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    int         c, n0;
    logic [6:0] rid;
    logic [7:0] rh, ra, rd, rs;

    initial begin
        reset_n      = 1'b0;
        chip_id      = CHIP;
        rx_data      = '0;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        for (int i = 0; i < 128; i++) mregs[i] = init_val(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wr_data", reg_wr_data, 0);
        check("rst_reg_wr_en", reg_wr_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        idle(2);

        // 1: write
        send_frame(8'h81, 8'h05, 8'hA5, 8'h21, 0, c);
        settle();
        check("t1_regmap5", regmap[5], 8'hA5);
        check("t1_err", err_count, 8'h00);

        // 2: read, ready held then toggling
        ready_mode = 0;
        n0 = tx_log.size();
        send_frame(8'h01, 8'h05, 8'h00, 8'h04, 0, c);
        settle();
        check_log(n0, 32'h0105A5A1, "t2_resp");
        ready_mode = 1;
        n0 = tx_log.size();
        send_frame(8'h01, 8'h05, 8'h00, 8'h04, 2, c);
        settle();
        check_log(n0, 32'h0105A5A1, "t2_resp_toggle");
        ready_mode = 0;

        // 3: bad checksum, out-of-range address
        send_frame(8'h81, 8'h05, 8'hA5, 8'h22, 0, c);
        settle();
        check("t3_err_csum", err_count, 8'h01);
        send_frame(8'h81, 8'h50, 8'h00, 8'hD1, 0, c);
        settle();
        check("t3_err_range", err_count, 8'h02);

        // 4: timeout, then recovery, then the longest legal gaps
        send_byte(8'h81, 1'b0, c);
        check("t4_busy", busy, 1'b1);
        send_byte(8'h05, 1'b0, c);
        idle(TIMEOUT);
        model_err();
        check("t4_busy_after_to", busy, 1'b0);
        check("t4_err_to", err_count, 8'h03);
        send_frame(8'h81, 8'h07, 8'h5A, 8'hDC, 1, c);
        settle();
        check("t4_regmap7", regmap[7], 8'h5A);
        send_byte(8'h81, 1'b0, c);
        idle(TIMEOUT - 1);
        send_byte(8'h06, 1'b0, c);
        idle(TIMEOUT - 1);
        send_byte(8'h3E, 1'b0, c);
        idle(TIMEOUT - 1);
        send_byte(8'hB9, 1'b0, c);
        expect_frame(8'h81, 8'h06, 8'h3E, 8'hB9, c);
        settle();
        check("t4_regmap6", regmap[6], 8'h3E);
        check("t4_err_gap", err_count, 8'h03);

        // 5: broadcast write, foreign id, readback
        send_frame(8'hFF, 8'h10, 8'h3C, 8'hD3, 0, c);
        settle();
        check("t5_regmap16", regmap[16], 8'h3C);
        send_frame(8'h02, 8'h05, 8'h00, 8'h07, 0, c);
        settle();
        check("t5_err_foreign", err_count, 8'h03);
        n0 = tx_log.size();
        send_frame(8'h01, 8'h10, 8'h00, 8'h11, 0, c);
        settle();
        check_log(n0, 32'h01103C2D, "t5_readback");

        // stray bytes in EXEC and RESP, frame errors
        send_frame(8'h81, 8'h08, 8'h77, 8'hFE, 0, c);
        send_byte(8'h55, 1'b0, c);
        model_err();
        settle();
        check("stray_exec_regmap8", regmap[8], 8'h77);
        send_frame(8'h81, 8'h50, 8'h00, 8'hD1, 0, c);
        send_byte(8'h55, 1'b0, c);
        settle();
        check("stray_exec_once", err_count, 8'h05);
        ready_mode = 3;
        n0 = tx_log.size();
        send_frame(8'h01, 8'h08, 8'h00, 8'h09, 0, c);
        idle(3);
        send_byte(8'hAA, 1'b0, c);
        model_err();
        ready_mode = 0;
        settle();
        check_log(n0, 32'h0108777E, "stray_resp");
        send_byte(8'h33, 1'b1, c);
        model_err();
        send_byte(8'h81, 1'b0, c);
        send_byte(8'h05, 1'b1, c);
        model_err();
        settle();
        check("ferr_err", err_count, 8'h08);

        // 6: reset while the second response byte is presented
        ready_mode = 0;
        send_frame(8'h01, 8'h05, 8'h00, 8'h04, 0, c);
        idle(2);
        check("t6_txv_pre", tx_valid, 1'b1);
        check("t6_txd_pre", tx_data, 8'h05);
        #1 reset_n = 1'b0;
        #1;
        check("t6_txv_rst", tx_valid, 1'b0);
        check("t6_busy_rst", busy, 1'b0);
        check("t6_err_rst", err_count, 8'h00);
        merr = 0;
        idle(2);
        reset_n = 1'b1;
        idle(2);
        n0 = tx_log.size();
        send_frame(8'h01, 8'h05, 8'h00, 8'h04, 0, c);
        settle();
        check_log(n0, 32'h0105A5A1, "t6_resp_after_rst");

        // randomized frames
        for (int n = 0; n < 150; n++) begin
            ready_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rid = CHIP;
                5, 6:          rid = BC;
                default: begin
                    do rid = 7'($urandom); while (rid == CHIP || rid == BC);
                end
            endcase
            rh = {1'($urandom_range(0, 1)), rid};
            ra = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(67, 255))
                                             : 8'($urandom_range(0, 66));
            if (rid == BC && !rh[7]) ra = 8'($urandom_range(0, 66));
            rd = 8'($urandom);
            rs = rh ^ ra ^ rd;
            if ($urandom_range(0, 6) == 0) rs = rs ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 9) == 0) begin
                send_byte(rh, 1'b0, c);
                idle($urandom_range(0, 2));
                send_byte(ra, 1'b1, c);
                model_err();
            end else begin
                send_frame(rh, ra, rd, rs, 3, c);
            end
            settle();
        end

        // saturation
        ready_mode = 0;
        for (int n = 0; n < 300; n++) begin
            send_byte(8'($urandom), 1'b1, c);
            model_err();
        end
        settle();
        check("sat_err", err_count, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
Byte-level command decoder between the UART receiver and the configuration register map. It consumes received bytes from the posi path and assembles 4-byte command frames. It issues register writes, or performs register reads and streams a 4-byte response to the piso UART transmitter. It also owns framing recovery (inter-byte timeout, checksum, address range) and counts errors.

Parameters:
NUMREGS, 67, number of configuration registers; valid addresses are 0..NUMREGS-1.
TIMEOUT_CYCLES, 4096, maximum clk cycles allowed between bytes of one frame.
BROADCAST_ID, 7'h7F, chip ID accepted by every chip (writes only).

Ports:
clk  input  1  system clock (the UART clock).
reset_n  input  1  asynchronous reset, active low.
chip_id  input  7  this chip's ID, static after reset.
rx_data  input  8  received byte.
rx_valid  input  1  one-cycle strobe; rx_data is valid.
rx_frame_err  input  1  qualifies rx_valid; stop-bit error on this byte.
reg_addr  output  7  register address for write and read.
reg_wr_data  output  8  write data.
reg_wr_en  output  1  one-cycle register write strobe.
reg_rd_data  input  8  combinational read data of config_bits[reg_addr].
tx_data  output  8  response byte to UART TX.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  UART TX accepts the byte on this edge.
err_count  output  8  saturating error counter.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Frame format, in order: HDR {wr, id[6:0]}, ADDR, DATA, CSUM. CSUM = HDR^ADDR^DATA. DATA is a don't-care for reads but is still included in CSUM.
- Response format: {1'b0, chip_id}, ADDR, reg_rd_data, XOR of the three.
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset is asynchronous, so asserting it mid-frame or mid-response drops tx_valid immediately. No partial write occurs.
- States: IDLE -> GET_ADDR -> GET_DATA -> GET_CSUM -> EXEC -> (RESP | IDLE).
  - Each transition out of IDLE and the GET_* states happens on rx_valid with rx_frame_err=0.
  - Any rx_valid with rx_frame_err=1 in IDLE or GET_*: discard the frame, go to IDLE, err_count+1.
- Timeout: the counter runs in GET_* states and clears on every rx_valid. When it reaches TIMEOUT_CYCLES-1: go to IDLE, err_count+1.
- On CSUM arrival: a mismatch sends the FSM to IDLE with err_count+1. No write, no response.
- EXEC lasts one cycle, entered the cycle after the CSUM byte. The accepting conditions below apply only with a matching checksum.
  - id==chip_id, wr=1, addr<NUMREGS: reg_wr_en=1 for exactly that cycle. reg_addr and reg_wr_data are valid in the same cycle. Then IDLE; no response.
  - id==BROADCAST_ID, wr=1: same as the previous case.
  - id==chip_id, wr=0, addr<NUMREGS: latch reg_rd_data; go to RESP.
  - Address out of range, for a frame addressed to this chip or broadcast: err_count+1, IDLE.
  - Foreign ID, or broadcast read: IDLE silently; no error.
- RESP: present the 4 response bytes in order.
  - tx_valid is asserted the cycle after EXEC.
  - tx_data and tx_valid are held stable until sampled with tx_ready=1, then the next byte is presented in the following cycle.
  - tx_valid deasserts after the 4th byte is accepted; state returns to IDLE.
- rx_valid in EXEC or RESP: the byte is dropped and err_count+1.
- err_count saturates at 8'hFF. Simultaneous error sources in one cycle count once.
- reg_addr holds its last value in IDLE. reg_wr_data updates only when DATA is captured.

Decomposition:
- Package psd_cmd_pkg holds:
  - the state enum;
  - FRAME_BYTES=4;
  - the WR_BIT index (7);
  - the BROADCAST_ID default;
  - a function cmd_csum(hdr, addr, data).
- One sub-module, cmd_timeout, holds the inter-byte counter: inputs clear/enable, output expired. It is parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Write: chip_id=01, bytes 81,05,A5,21 -> reg_wr_en pulse with reg_addr=05 and reg_wr_data=A5, one cycle after the CSUM strobe; no tx_valid; err_count=0.
2. Read: regmap[05]=A5, bytes 01,05,00,04, tx_ready held 1 -> tx bytes 01,05,A5,A1, with tx_valid first high 2 cycles after the CSUM strobe. Repeat with tx_ready toggling every 3 cycles -> same bytes, each held stable.
3. Bad checksum 81,05,A5,22 -> no write, no response, err_count=1. An out-of-range address 81,50,00,D1 (CSUM = 81^50^00) -> no write, err_count=2.
4. Timeout: send 81,05, then a TIMEOUT_CYCLES idle gap -> IDLE, err_count+1. A following valid frame executes normally.
5. Broadcast: FF,10,3C,D3 -> write to addr 10 regardless of chip_id. A foreign-ID frame 02,05,00,07 -> silent, err_count unchanged.
6. Reset asserted during RESP byte 2 -> tx_valid low asynchronously, busy=0, err_count=0. A subsequent read frame responds correctly.
